noc_output_port_arbiter: RTL
============================

// Module: noc_output_port_arbiter
// PURPOSE
// - Per-output-port wormhole arbiter for the NoC router; one instance per output (NUM_PORTS per router).
// - Shares one output link between NUM_INPUTS input flit buffers, round-robin at packet granularity.
// - Tracks downstream credits (FLIT_BUFFER_DEPTH) and drives the crossbar select and send_out for that link.
// PARAMETERS
// - NUM_INPUTS         5   requesters; input 0 = local injection, 1..4 = N/S/E/W
// - FLIT_BUFFER_DEPTH  8   downstream buffer depth = initial and maximum credit count
// - CREDIT_WIDTH       $clog2(FLIT_BUFFER_DEPTH+1)  localparam, credit counter width
// - SEL_WIDTH          $clog2(NUM_INPUTS)           localparam, select index width
// PORTS
// - clk_noc       in   1           NoC clock; single clock domain
// - rst_noc_sync  in   1           synchronous reset, active-high
// - req           in   NUM_INPUTS  req[i]=1: input i head-of-queue flit is routed to this output
// - req_is_tail   in   NUM_INPUTS  tail flag of input i head-of-queue flit
// - turn_disable  in   NUM_INPUTS  1 = turn from input i to this output forbidden; static outside reset
// - grant         out  NUM_INPUTS  one-hot, combinational; input i flit dequeued this cycle
// - sel_out       out  SEL_WIDTH   registered crossbar select, valid with send_out
// - send_out      out  1           registered; flit on link this cycle
// - is_tail_out   out  1           registered tail flag of the flit being sent
// - credit_in     in   1           downstream returns one buffer slot
// - credits       out  CREDIT_WIDTH current credit count
// - locked        out  1           packet in progress (state LOCKED)
// - credit_err    out  1           sticky; credit_in received while credits == FLIT_BUFFER_DEPTH
// BEHAVIOUR
// - Reset: state=IDLE, rr_ptr=0, owner=0, credits=FLIT_BUFFER_DEPTH; grant/send_out/is_tail_out/sel_out/locked/credit_err=0.
// - eligible[i] = req[i] & ~turn_disable[i]; arbitration proceeds only when credits != 0 (registered value).
// - IDLE: winner = first eligible index scanning rr_ptr, rr_ptr+1, ... wrapping modulo NUM_INPUTS.
//   - grant[winner]=1 same cycle. Tail flit (single-flit packet): stay IDLE, rr_ptr <= winner+1 (wrap).
//   - Non-tail: -> LOCKED, owner <= winner.
// - LOCKED: only owner considered; grant[owner]=req[owner] & (credits!=0); turn_disable ignored.
//   - Tail granted -> IDLE, rr_ptr <= owner+1 (wrap). No flit from owner: hold LOCKED, no grant.
// - Latency: grant at cycle N -> send_out=1, sel_out=index, is_tail_out=tail at N+1; one flit/cycle max.
// - Credits: next = credits - |grant + credit_in; grant and credit_in in the same cycle -> unchanged.
//   - credits==0: no grant, even if credit_in arrives that cycle (it is usable from the next cycle).
//   - credit_in at credits==FLIT_BUFFER_DEPTH: count saturates, credit_err <= 1 until reset.
// - rr_ptr advances only on packet completion, never on a stalled or idle cycle.
// - Reset mid-packet: back to IDLE and full credits at the next edge; no flit is issued on the reset cycle.
// - grant is never asserted for an input with req=0. At most one bit is set.
// CONFIGURATION
// - NOC_ARB_STATS_EN defined: adds ports flit_count (out, 32) and stall_count (out, 32); both reset to 0.
//   - flit_count increments per send_out. stall_count increments each cycle with any eligible/owner
//     request while credits==0. Both saturate at 2^32-1.
// - Undefined: those ports and counters do not exist; all other behaviour is identical.
// TESTING
// - Reset, then req=5'b00110 single-flit tails held -> grants alternate 1,2,1,2; send_out at N+1; credits 8,7,6...
// - Input 3 sends 4-flit packet; input 1 requests at flit 2 -> grant stays at 3 until tail, then grant 1.
// - No credit_in for 8 flits -> credits=0, grant=0; one credit_in -> exactly one more grant next cycle.
// - Same cycle grant + credit_in at credits=4 -> credits stays 4; credit_in at credits=8 -> credit_err=1, credits=8.
// - turn_disable=5'b00001, req=5'b00001 -> never granted; rst_noc_sync mid-packet -> IDLE, credits=8.
// - NOC_ARB_STATS_EN: 10 flits sent, 3 zero-credit stall cycles -> flit_count=10, stall_count=3.

Source files
------------

// File: rtl/noc_output_port_arbiter_if.sv
// Router-side bundle for one output-port arbiter: input requests in, grant and link outputs back.
// The arbiter uses the slave modport; the input buffers and link logic use the master modport.
interface noc_output_port_arbiter_if #(
  parameter int unsigned NUM_INPUTS        = 5,
  parameter int unsigned FLIT_BUFFER_DEPTH = 8
);
  localparam int unsigned CREDIT_WIDTH = $clog2(FLIT_BUFFER_DEPTH + 1);
  localparam int unsigned SEL_WIDTH    = $clog2(NUM_INPUTS);

  logic [NUM_INPUTS-1:0]   req;
  logic [NUM_INPUTS-1:0]   req_is_tail;
  logic [NUM_INPUTS-1:0]   turn_disable;
  logic [NUM_INPUTS-1:0]   grant;
  logic [SEL_WIDTH-1:0]    sel_out;
  logic                    send_out;
  logic                    is_tail_out;
  logic                    credit_in;
  logic [CREDIT_WIDTH-1:0] credits;
  logic                    locked;
  logic                    credit_err;

  modport master (
    output req, req_is_tail, turn_disable, credit_in,
    input  grant, sel_out, send_out, is_tail_out, credits, locked, credit_err
  );

  modport slave (
    input  req, req_is_tail, turn_disable, credit_in,
    output grant, sel_out, send_out, is_tail_out, credits, locked, credit_err
  );
endinterface

// File: rtl/noc_output_port_arbiter.sv
// Wormhole output-port arbiter: packet-granular round-robin with downstream credit tracking.
// Define NOC_ARB_STATS_EN to add the saturating flit_count / stall_count statistics ports.
module noc_output_port_arbiter #(
  parameter int unsigned NUM_INPUTS        = 5,
  parameter int unsigned FLIT_BUFFER_DEPTH = 8
) (
  input logic                      clk_noc,
  input logic                      rst_noc_sync,
  noc_output_port_arbiter_if.slave bus
`ifdef NOC_ARB_STATS_EN
  ,
  output logic [31:0]              flit_count,
  output logic [31:0]              stall_count
`endif
);
  localparam int unsigned CREDIT_WIDTH = $clog2(FLIT_BUFFER_DEPTH + 1);
  localparam int unsigned SEL_WIDTH    = $clog2(NUM_INPUTS);
  localparam logic [CREDIT_WIDTH-1:0] MaxCredits = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);
  localparam logic [SEL_WIDTH-1:0]    LastIdx    = SEL_WIDTH'(NUM_INPUTS - 1);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e                  state_q, state_d;
  logic [SEL_WIDTH-1:0]    rr_q, rr_d, owner_q, owner_d, win, cand, sel_q;
  logic [CREDIT_WIDTH-1:0] credits_q, credits_d;
  logic [NUM_INPUTS-1:0]   eligible, grant;
  logic                    has_credit, any_grant, found, credit_err_q, send_q, tail_q;

  function automatic logic [SEL_WIDTH-1:0] wrap_inc(input logic [SEL_WIDTH-1:0] idx);
    return (idx == LastIdx) ? '0 : idx + SEL_WIDTH'(1);
  endfunction

  assign eligible   = bus.req & ~bus.turn_disable;
  assign has_credit = (credits_q != '0);

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    grant   = '0;
    win     = '0;
    cand    = '0;
    found   = 1'b0;
    unique case (state_q)
      StIdle: begin
        for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
          cand = SEL_WIDTH'((32'(rr_q) + k) % NUM_INPUTS);
          if (!found && eligible[cand]) begin
            found = 1'b1;
            win   = cand;
          end
        end
        if (found && has_credit && !rst_noc_sync) begin
          grant[win] = 1'b1;
          if (bus.req_is_tail[win]) begin
            rr_d = wrap_inc(win);
          end else begin
            state_d = StLocked;
            owner_d = win;
          end
        end
      end
      StLocked: begin
        // Owner keeps the link until its tail; turn_disable was already checked at packet start.
        win = owner_q;
        if (bus.req[owner_q] && has_credit && !rst_noc_sync) begin
          grant[win] = 1'b1;
          if (bus.req_is_tail[win]) begin
            state_d = StIdle;
            rr_d    = wrap_inc(owner_q);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign any_grant = |grant;

  always_comb begin
    credits_d = credits_q;
    unique case ({any_grant, bus.credit_in})
      2'b10:   credits_d = credits_q - CREDIT_WIDTH'(1);
      2'b01:   if (credits_q != MaxCredits) credits_d = credits_q + CREDIT_WIDTH'(1);
      default: credits_d = credits_q;
    endcase
  end

  always_ff @(posedge clk_noc) begin
    if (rst_noc_sync) begin
      state_q      <= StIdle;
      rr_q         <= '0;
      owner_q      <= '0;
      credits_q    <= MaxCredits;
      credit_err_q <= 1'b0;
      send_q       <= 1'b0;
      sel_q        <= '0;
      tail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      owner_q      <= owner_d;
      credits_q    <= credits_d;
      credit_err_q <= credit_err_q | (bus.credit_in && (credits_q == MaxCredits));
      send_q       <= any_grant;
      sel_q        <= any_grant ? win : '0;
      tail_q       <= any_grant & bus.req_is_tail[win];
    end
  end

  assign bus.grant       = grant;
  assign bus.send_out    = send_q;
  assign bus.sel_out     = sel_q;
  assign bus.is_tail_out = tail_q;
  assign bus.credits     = credits_q;
  assign bus.locked      = (state_q == StLocked);
  assign bus.credit_err  = credit_err_q;

`ifdef NOC_ARB_STATS_EN
  logic [31:0] flit_q, stall_q;
  logic        stall_req;

  assign stall_req = (state_q == StIdle) ? |eligible : bus.req[owner_q];

  always_ff @(posedge clk_noc) begin
    if (rst_noc_sync) begin
      flit_q  <= '0;
      stall_q <= '0;
    end else begin
      if (any_grant && (flit_q != '1)) flit_q <= flit_q + 32'd1;
      if (stall_req && !has_credit && (stall_q != '1)) stall_q <= stall_q + 32'd1;
    end
  end

  assign flit_count  = flit_q;
  assign stall_count = stall_q;
`endif
endmodule
